redun_mont_sq_seq: RTL and testbench
====================================

Name: redun_mont_sq_seq

Overview:
- Sequencer for the redundant-form Montgomery squaring core (redun_mont), which free-runs once started: one squared result, o_val, per three-multiply round.
- This block accepts a start value and iteration count T, then resets and launches the core.
- It counts core result pulses, captures the T-th result, then holds the core in reset to stop it.
- It is the host-facing front end of the VDF squaring loop.

Parameters:
- NUM_WRDS, 65, number of redundant words per operand (matches core).
- WRD_BITS, 16, payload bits per word; each word is WRD_BITS+1 wide.
- CNT_BITS, 40, width of iteration counter.
- RST_CYCLES, 4, cycles core reset is held before each launch (minimum 1).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_start_val, in, 1, start request valid.
- o_start_rdy, out, 1, high only in IDLE.
- i_start_sq, in, NUM_WRDS x (WRD_BITS+1), initial value, redundant Montgomery form.
- i_iter, in, CNT_BITS, number of squarings T.
- i_abort, in, 1, abandon current job.
- o_res, out, NUM_WRDS x (WRD_BITS+1), result after T squarings.
- o_res_val, out, 1, result valid.
- i_res_rdy, in, 1, result accepted.
- o_busy, out, 1, high in any state except IDLE.
- o_iter_cnt, out, CNT_BITS, squarings completed in current job.
- o_core_rst, out, 1, reset to core.
- o_core_sq, out, NUM_WRDS x (WRD_BITS+1), core input operand.
- o_core_val, out, 1, core start pulse.
- i_core_mul, in, NUM_WRDS x (WRD_BITS+1), core result.
- i_core_val, in, 1, core result pulse.

Behaviour:
- Reset (i_rst synchronous, active-high; clock i_clk):
  - State = IDLE.
  - o_core_rst = 1; o_core_val = 0; o_res_val = 0.
  - o_res = 0; o_core_sq = 0; o_iter_cnt = 0.
  - o_start_rdy = 1 at the first cycle after reset deasserts.
- Core reset in IDLE: held asserted the whole time (keeps the core idle).
- Accept: a start is accepted when i_start_val && o_start_rdy.
  - i_start_sq and i_iter are latched into job registers; o_core_sq is loaded from i_start_sq.
  - o_core_sq is held constant until the job ends (the core re-registers its input every cycle).
- IDLE to DONE directly: taken on accept with i_iter == 0.
  - o_res = i_start_sq, o_res_val = 1 the next cycle.
  - Core is never released.
- IDLE to CRST: taken on accept with i_iter != 0.
  - o_iter_cnt is cleared.
  - A reset counter is loaded with RST_CYCLES.
- CRST: o_core_rst = 1 for exactly RST_CYCLES cycles, then go to LAUNCH.
- LAUNCH: lasts one cycle.
  - o_core_rst = 0 and o_core_val = 1.
  - Then go to RUN.
- RUN: o_core_rst = 0 and o_core_val = 0.
  - Each i_core_val increments o_iter_cnt.
  - On the pulse where the count reaches T, o_res latches i_core_mul in the same edge.
  - Next state is DONE; o_core_rst is asserted from that next cycle on.
  - Later core pulses are ignored.
  - i_core_val outside RUN is ignored; o_iter_cnt is unchanged.
- DONE:
  - o_res_val = 1 and o_core_rst = 1; o_res is held stable.
  - On i_res_rdy, o_res_val drops and state returns to IDLE the next cycle.
  - o_res_val and o_start_rdy are never high in the same cycle.
- Abort: i_abort in CRST, LAUNCH or RUN goes to IDLE the next cycle.
  - o_core_rst = 1 from that cycle on; no result is produced.
  - o_iter_cnt keeps its value.
- Abort outside those states: in IDLE or DONE, i_abort has no effect.
- Abort priority: i_abort beats a coincident final i_core_val, so o_res is not updated.
- Counter width: the counter is CNT_BITS wide with no wrap; T max = 2^CNT_BITS - 1.
- Start during job: i_start_val while busy is not accepted; the host must hold it.
- Latency: accept to o_core_val = RST_CYCLES + 1 cycles.
- States: one-hot, 5 states; an illegal encoding recovers to IDLE with the core held in reset.

Test Plan:
- T=0: i_start_sq = word pattern 0x1..0x41, i_iter=0 -> o_res_val the cycle after accept, o_res equal to input, o_core_val never pulses.
- Launch timing: T=3, RST_CYCLES=4, core model pulses i_core_val every 3 cycles -> o_core_val 5 cycles after accept; o_iter_cnt 1,2,3; o_res equals the 3rd i_core_mul; o_core_rst rises the cycle after.
- Stall: T=1, hold i_res_rdy=0 for 10 cycles, core keeps pulsing before it is reset -> o_res stable, o_iter_cnt=1, back-to-back start accepted only after the i_res_rdy cycle.
- Abort coincident with final pulse: T=5, i_abort on the same cycle as the 5th i_core_val -> IDLE, no o_res_val, o_res unchanged, o_core_rst=1.
- Reset mid-RUN: i_rst at count 2 of T=10 -> all outputs at reset values next cycle, o_start_rdy=1 after release, fresh T=2 job completes correctly.
- End to end: real redun_mont with small modulus -> o_res matches the software model of x^(2^T)·R mod N for T=1,2,17.

Source files
------------

// File: rtl/redun_mont_sq_seq_if.sv
// Host-facing job interface of the Montgomery squaring sequencer: start request,
// iteration count, abort, and result handshake.
interface redun_mont_sq_seq_if #(
    parameter int NUM_WRDS = 65,
    parameter int WRD_BITS = 16,
    parameter int CNT_BITS = 40
);
    logic                               start_val;
    logic                               start_rdy;
    logic [NUM_WRDS-1:0][WRD_BITS:0]    start_sq;
    logic [CNT_BITS-1:0]                iter;
    logic                               abort;
    logic [NUM_WRDS-1:0][WRD_BITS:0]    res;
    logic                               res_val;
    logic                               res_rdy;
    logic                               busy;
    logic [CNT_BITS-1:0]                iter_cnt;

    modport master (
        output start_val, start_sq, iter, abort, res_rdy,
        input  start_rdy, res, res_val, busy, iter_cnt
    );

    modport slave (
        input  start_val, start_sq, iter, abort, res_rdy,
        output start_rdy, res, res_val, busy, iter_cnt
    );
endinterface

// File: rtl/redun_mont_sq_seq.sv
// Sequencer for the free-running redundant Montgomery squaring core: resets and
// launches the core, counts T result pulses, captures the last one, then parks the core.
module redun_mont_sq_seq #(
    parameter int NUM_WRDS   = 65,
    parameter int WRD_BITS   = 16,
    parameter int CNT_BITS   = 40,
    parameter int RST_CYCLES = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    redun_mont_sq_seq_if.slave              host,
    output logic                            o_core_rst,
    output logic [NUM_WRDS-1:0][WRD_BITS:0] o_core_sq,
    output logic                            o_core_val,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0] i_core_mul,
    input  logic                            i_core_val
);
    localparam int RC_BITS = $clog2(RST_CYCLES + 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        CRST   = 5'b00010,
        LAUNCH = 5'b00100,
        RUN    = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t              state;
    logic [CNT_BITS-1:0] job_iter;
    logic [RC_BITS-1:0]  rst_cnt;
    logic [CNT_BITS-1:0] cnt_inc;
    logic                accept;

    assign cnt_inc = host.iter_cnt + CNT_BITS'(1);
    assign accept  = host.start_val && host.start_rdy;

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            job_iter       <= '0;
            rst_cnt        <= '0;
            o_core_rst     <= 1'b1;
            o_core_val     <= 1'b0;
            o_core_sq      <= '0;
            host.res       <= '0;
            host.res_val   <= 1'b0;
            host.iter_cnt  <= '0;
            host.start_rdy <= 1'b1;
            host.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_core_sq      <= host.start_sq;
                        job_iter       <= host.iter;
                        host.iter_cnt  <= '0;
                        host.start_rdy <= 1'b0;
                        host.busy      <= 1'b1;
                        if (host.iter == '0) begin
                            // Zero squarings: the start value is already the answer.
                            state        <= DONE;
                            host.res     <= host.start_sq;
                            host.res_val <= 1'b1;
                        end else begin
                            state   <= CRST;
                            rst_cnt <= RC_BITS'(RST_CYCLES);
                        end
                    end
                end
                CRST: begin
                    if (host.abort) begin
                        state          <= IDLE;
                        host.start_rdy <= 1'b1;
                        host.busy      <= 1'b0;
                    end else if (rst_cnt == RC_BITS'(1)) begin
                        state      <= LAUNCH;
                        o_core_rst <= 1'b0;
                        o_core_val <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RC_BITS'(1);
                    end
                end
                LAUNCH: begin
                    o_core_val <= 1'b0;
                    if (host.abort) begin
                        state          <= IDLE;
                        o_core_rst     <= 1'b1;
                        host.start_rdy <= 1'b1;
                        host.busy      <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a coincident result pulse, including the final one.
                    if (host.abort) begin
                        state          <= IDLE;
                        o_core_rst     <= 1'b1;
                        host.start_rdy <= 1'b1;
                        host.busy      <= 1'b0;
                    end else if (i_core_val) begin
                        host.iter_cnt <= cnt_inc;
                        if (cnt_inc == job_iter) begin
                            state        <= DONE;
                            o_core_rst   <= 1'b1;
                            host.res     <= i_core_mul;
                            host.res_val <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (host.res_rdy) begin
                        state          <= IDLE;
                        host.res_val   <= 1'b0;
                        host.start_rdy <= 1'b1;
                        host.busy      <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    o_core_rst     <= 1'b1;
                    o_core_val     <= 1'b0;
                    host.res_val   <= 1'b0;
                    host.start_rdy <= 1'b1;
                    host.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_redun_mont_sq_seq.sv
// Directed bench for redun_mont_sq_seq: the core is emulated by hand-placed result
// pulses so launch latency, stall, abort and reset corners can be pinned exactly.
module tb_redun_mont_sq_seq;
    localparam int NW = 65;
    localparam int WB = 16;
    localparam int CB = 40;
    localparam int RC = 4;

    typedef logic [NW-1:0][WB:0] word_vec_t;

    logic      clk = 1'b0;
    logic      rst;
    logic      core_rst;
    logic      core_val_o;
    logic      core_val_i;
    word_vec_t core_sq;
    word_vec_t core_mul;

    int n_vec    = 0;
    int n_bad    = 0;
    int launches = 0;

    redun_mont_sq_seq_if #(.NUM_WRDS(NW), .WRD_BITS(WB), .CNT_BITS(CB)) host_if ();

    redun_mont_sq_seq #(
        .NUM_WRDS(NW), .WRD_BITS(WB), .CNT_BITS(CB), .RST_CYCLES(RC)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .host       (host_if),
        .o_core_rst (core_rst),
        .o_core_sq  (core_sq),
        .o_core_val (core_val_o),
        .i_core_mul (core_mul),
        .i_core_val (core_val_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_val_o === 1'b1) launches++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int word_diff(input word_vec_t a, input word_vec_t b);
        int d = 0;
        for (int w = 0; w < NW; w++) if (a[w] !== b[w]) d++;
        return d;
    endfunction

    function automatic word_vec_t ramp(input int base);
        word_vec_t v;
        for (int w = 0; w < NW; w++) v[w] = 17'(base + w);
        return v;
    endfunction

    function automatic word_vec_t mul_pat(input int k);
        return ramp(k * 'h300 + 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input word_vec_t sq, input logic [CB-1:0] t);
        host_if.start_val = 1'b1;
        host_if.start_sq  = sq;
        host_if.iter      = t;
        tick();
        host_if.start_val = 1'b0;
    endtask

    task automatic wait_launch(output int n);
        n = 0;
        while (core_val_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("launch_seen", core_val_o, 1);
    endtask

    // Two quiet cycles, then one result pulse carrying mul_pat(k).
    task automatic pulse(input int k, input bit with_abort);
        core_val_i = 1'b0;
        tick();
        tick();
        core_val_i    = 1'b1;
        core_mul      = mul_pat(k);
        host_if.abort = with_abort;
        tick();
        core_val_i    = 1'b0;
        host_if.abort = 1'b0;
    endtask

    initial begin
        int n;
        int lbase;
        int unstable;

        rst               = 1'b1;
        core_val_i        = 1'b0;
        core_mul          = '0;
        host_if.start_val = 1'b0;
        host_if.start_sq  = '0;
        host_if.iter      = '0;
        host_if.abort     = 1'b0;
        host_if.res_rdy   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_core_val", core_val_o, 0);
        check("rst_res_val", host_if.res_val, 0);
        check("rst_res", word_diff(host_if.res, '0), 0);
        check("rst_core_sq", word_diff(core_sq, '0), 0);
        check("rst_iter_cnt", host_if.iter_cnt, 0);
        rst = 1'b0;
        tick();
        check("rst_start_rdy", host_if.start_rdy, 1);
        check("rst_busy", host_if.busy, 0);

        // T=0: result is the start value the cycle after accept, core never launched
        lbase = launches;
        start_job(ramp(1), 0);
        check("t0_res_val", host_if.res_val, 1);
        check("t0_res", word_diff(host_if.res, ramp(1)), 0);
        check("t0_start_rdy", host_if.start_rdy, 0);
        check("t0_core_rst", core_rst, 1);
        host_if.abort = 1'b1;
        tick();
        host_if.abort = 1'b0;
        check("t0_abort_in_done", host_if.res_val, 1);
        host_if.res_rdy = 1'b1;
        tick();
        host_if.res_rdy = 1'b0;
        check("t0_res_val_drop", host_if.res_val, 0);
        check("t0_back_idle", host_if.start_rdy, 1);
        check("t0_no_launch", launches - lbase, 0);

        // Abort in IDLE does nothing
        host_if.abort = 1'b1;
        tick();
        host_if.abort = 1'b0;
        check("idle_abort_rdy", host_if.start_rdy, 1);
        check("idle_abort_busy", host_if.busy, 0);

        // Launch timing, T=3
        start_job(ramp('h100), 3);
        check("t3_busy", host_if.busy, 1);
        check("t3_crst_core_rst", core_rst, 1);
        check("t3_core_sq", word_diff(core_sq, ramp('h100)), 0);
        wait_launch(n);
        check("t3_launch_lat", n + 1, RC + 1);
        check("t3_launch_core_rst", core_rst, 0);
        pulse(1, 0);
        check("t3_cnt1", host_if.iter_cnt, 1);
        pulse(2, 0);
        check("t3_cnt2", host_if.iter_cnt, 2);
        check("t3_run_core_rst", core_rst, 0);
        check("t3_no_early_res", host_if.res_val, 0);
        pulse(3, 0);
        check("t3_cnt3", host_if.iter_cnt, 3);
        check("t3_res_val", host_if.res_val, 1);
        check("t3_res", word_diff(host_if.res, mul_pat(3)), 0);
        check("t3_core_rst_after", core_rst, 1);
        host_if.res_rdy = 1'b1;
        tick();
        host_if.res_rdy = 1'b0;
        check("t3_idle", host_if.start_rdy, 1);

        // Stall in DONE, T=1, with extra core pulses and a pending start
        start_job(ramp('h200), 1);
        wait_launch(n);
        pulse(1, 0);
        check("st_res_val", host_if.res_val, 1);
        host_if.start_val = 1'b1;
        host_if.start_sq  = ramp('h300);
        host_if.iter      = 5;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            core_val_i = (i % 3 == 2);
            core_mul   = mul_pat(50 + i);
            tick();
            if (word_diff(host_if.res, mul_pat(1)) != 0 || host_if.res_val !== 1'b1 ||
                host_if.start_rdy !== 1'b0 || host_if.iter_cnt !== 40'd1)
                unstable++;
        end
        core_val_i = 1'b0;
        check("st_stable_cycles", unstable, 0);
        check("st_core_sq_held", word_diff(core_sq, ramp('h200)), 0);
        host_if.res_rdy = 1'b1;
        tick();
        host_if.res_rdy = 1'b0;
        check("st_rdy_after_ack", host_if.start_rdy, 1);
        check("st_res_val_low", host_if.res_val, 0);
        tick();
        host_if.start_val = 1'b0;
        check("st_b2b_accept", host_if.busy, 1);
        check("st_b2b_core_sq", word_diff(core_sq, ramp('h300)), 0);
        check("st_b2b_cnt_clr", host_if.iter_cnt, 0);

        // Abort coincident with the 5th pulse of the T=5 job
        wait_launch(n);
        for (int k = 1; k <= 4; k++) pulse(k, 0);
        pulse(5, 1);
        check("ab_res_val", host_if.res_val, 0);
        check("ab_idle", host_if.start_rdy, 1);
        check("ab_busy", host_if.busy, 0);
        check("ab_core_rst", core_rst, 1);
        check("ab_iter_cnt", host_if.iter_cnt, 4);
        check("ab_res_kept", word_diff(host_if.res, mul_pat(1)), 0);
        tick();
        check("ab_res_val_later", host_if.res_val, 0);

        // Reset in the middle of a T=10 run, then a clean T=2 job
        start_job(ramp('h400), 10);
        wait_launch(n);
        pulse(1, 0);
        pulse(2, 0);
        check("mr_cnt2", host_if.iter_cnt, 2);
        rst = 1'b1;
        tick();
        check("mr_core_rst", core_rst, 1);
        check("mr_core_val", core_val_o, 0);
        check("mr_res_val", host_if.res_val, 0);
        check("mr_res", word_diff(host_if.res, '0), 0);
        check("mr_core_sq", word_diff(core_sq, '0), 0);
        check("mr_iter_cnt", host_if.iter_cnt, 0);
        check("mr_busy", host_if.busy, 0);
        rst = 1'b0;
        tick();
        check("mr_start_rdy", host_if.start_rdy, 1);
        start_job(ramp('h500), 2);
        wait_launch(n);
        pulse(11, 0);
        pulse(12, 0);
        check("mr_t2_res_val", host_if.res_val, 1);
        check("mr_t2_res", word_diff(host_if.res, mul_pat(12)), 0);
        check("mr_t2_cnt", host_if.iter_cnt, 2);
        host_if.res_rdy = 1'b1;
        tick();
        host_if.res_rdy = 1'b0;
        check("mr_t2_idle", host_if.start_rdy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
